// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, stall encodings and load-type codes for the MEM stage.
// Rev 1.0
`default_nettype none

package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 84;
  localparam int MEM_TO_WB_WD = 75;
  localparam int MEM_TO_ID_WD = 38;
  localparam int STALL_BUS    = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LB  = 3'b001,
    LD_LBU = 3'b010,
    LD_LH  = 3'b011,
    LD_LHU = 3'b100
  } ld_type_e;

  // Field layout of the EX->MEM bus, MSB first.
  typedef struct packed {
    logic [4:0]  hilo_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic [2:0]  ld_type;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// load_align: byte/halfword selection with sign or zero extension for loads.
// Rev 1.0
`default_nettype none

module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused_off;

  // Halfword loads ignore the low offset bit; misalignment is not trapped here.
  assign w_unused_off = off[0];

  always_comb begin
    w_byte = 8'h00;
    case (off)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
  end

  assign w_half = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (ld_type)
      LD_LB:   result = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  result = {24'h000000, w_byte};
      LD_LH:   result = {{16{w_half[15]}}, w_half};
      LD_LHU:  result = {16'h0000, w_half};
      default: result = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage -- stage register, SRAM read-data capture, load alignment.
// Rev 1.0
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_fwd
);

  ex_mem_t     r_stage;
  logic [31:0] r_rdata;
  logic        r_rdata_held;

  logic        w_bubble;
  logic        w_advance;
  logic        w_is_load;
  logic [31:0] w_rdata;
  logic [31:0] w_aligned;
  logic [31:0] w_rf_wdata;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall[5], stall[2:0]};

  assign w_bubble  = (stall[3] == STOP) && (stall[4] == NO_STOP);
  assign w_advance = (stall[3] == NO_STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage      <= '0;
      r_rdata      <= 32'h0;
      r_rdata_held <= 1'b0;
    end else if (flush || w_bubble) begin
      r_stage      <= '0;
      r_rdata_held <= 1'b0;
    end else if (w_advance) begin
      r_stage      <= ex_mem_t'(ex_to_mem_bus);
      r_rdata_held <= 1'b0;
    end else if (!r_rdata_held) begin
      // SRAM data is only valid in the first MEM cycle; keep it while stalled.
      r_rdata      <= data_sram_rdata;
      r_rdata_held <= 1'b1;
    end
  end

  assign w_rdata   = r_rdata_held ? r_rdata : data_sram_rdata;
  assign w_is_load = r_stage.data_ram_en && (r_stage.data_ram_wen == 4'h0) && r_stage.sel_rf_res;

  load_align u_load_align (
    .rdata   (w_rdata),
    .off     (r_stage.ex_result[1:0]),
    .ld_type (r_stage.ld_type),
    .result  (w_aligned)
  );

  assign w_rf_wdata = w_is_load ? w_aligned : r_stage.ex_result;

  assign mem_to_wb_bus = {r_stage.hilo_op, r_stage.pc, r_stage.rf_we, r_stage.rf_waddr, w_rf_wdata};
  assign mem_to_id_fwd = {r_stage.rf_we, r_stage.rf_waddr, w_rf_wdata};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for the MEM stage.
// Rev 1.0
`default_nettype none

module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic [83:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [74:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_fwd;

  int total;
  int fails;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_fwd   (mem_to_id_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [83:0] mk(input logic [4:0] hilo, input logic [31:0] pc,
                                     input logic en, input logic [3:0] wen, input logic [2:0] ld,
                                     input logic sel, input logic we, input logic [4:0] wa,
                                     input logic [31:0] res);
    return {hilo, pc, en, wen, ld, sel, we, wa, res};
  endfunction

  task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the write-back bus and that the forwarding bus mirrors it.
  task automatic chk_out(input string tag, input logic [4:0] hilo, input logic [31:0] pc,
                         input logic we, input logic [4:0] wa, input logic [31:0] wdata);
    chk(tag, mem_to_wb_bus, {hilo, pc, we, wa, wdata});
    chk({tag, "_fwd"}, {37'h0, mem_to_id_fwd}, {37'h0, we, wa, wdata});
  endtask

  // Presents an entry on the EX bus and moves to the negedge after it is clocked in.
  task automatic issue(input logic [83:0] bus);
    ex_to_mem_bus = bus;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst = 1'b1;
    flush = 1'b0;
    stall = 6'b0;
    ex_to_mem_bus = '0;
    data_sram_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk_out("reset", 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    rst = 1'b0;

    // LB / LBU from byte 3
    issue(mk(5'h0, 32'hBFC0_0000, 1'b1, 4'h0, 3'b001, 1'b1, 1'b1, 5'd5, 32'h0000_1003));
    data_sram_rdata = 32'h80AA_BBCC; #1;
    chk_out("lb", 5'h0, 32'hBFC0_0000, 1'b1, 5'd5, 32'hFFFF_FF80);
    issue(mk(5'h0, 32'hBFC0_0004, 1'b1, 4'h0, 3'b010, 1'b1, 1'b1, 5'd5, 32'h0000_1003));
    data_sram_rdata = 32'h80AA_BBCC; #1;
    chk_out("lbu", 5'h0, 32'hBFC0_0004, 1'b1, 5'd5, 32'h0000_0080);

    // Halfword loads
    issue(mk(5'h0, 32'hBFC0_0008, 1'b1, 4'h0, 3'b100, 1'b1, 1'b1, 5'd6, 32'h0000_2002));
    data_sram_rdata = 32'hBEEF_1234; #1;
    chk_out("lhu", 5'h0, 32'hBFC0_0008, 1'b1, 5'd6, 32'h0000_BEEF);
    issue(mk(5'h0, 32'hBFC0_000C, 1'b1, 4'h0, 3'b011, 1'b1, 1'b1, 5'd6, 32'h0000_2000));
    data_sram_rdata = 32'h0000_8001; #1;
    chk_out("lh", 5'h0, 32'hBFC0_000C, 1'b1, 5'd6, 32'hFFFF_8001);

    // LB from byte 1 and reserved ld_type treated as LW
    issue(mk(5'h0, 32'hBFC0_0010, 1'b1, 4'h0, 3'b001, 1'b1, 1'b1, 5'd8, 32'h0000_0001));
    data_sram_rdata = 32'h1122_7F44; #1;
    chk_out("lb_b1", 5'h0, 32'hBFC0_0010, 1'b1, 5'd8, 32'h0000_007F);
    issue(mk(5'h0, 32'hBFC0_0014, 1'b1, 4'h0, 3'b111, 1'b1, 1'b1, 5'd8, 32'h0000_0003));
    data_sram_rdata = 32'h8765_4321; #1;
    chk_out("ld_rsvd", 5'h0, 32'hBFC0_0014, 1'b1, 5'd8, 32'h8765_4321);

    // ALU op and store carry ex_result; hilo_op/pc pass through
    issue(mk(5'h13, 32'hBFC0_0018, 1'b0, 4'h0, 3'b001, 1'b0, 1'b1, 5'd9, 32'h1234_5678));
    data_sram_rdata = 32'hFFFF_FFFF; #1;
    chk_out("alu", 5'h13, 32'hBFC0_0018, 1'b1, 5'd9, 32'h1234_5678);
    issue(mk(5'h0, 32'hBFC0_001C, 1'b1, 4'hF, 3'b000, 1'b1, 1'b0, 5'd0, 32'hABCD_0010));
    data_sram_rdata = 32'h5555_5555; #1;
    chk_out("store", 5'h0, 32'hBFC0_001C, 1'b0, 5'd0, 32'hABCD_0010);

    // LW held across a three-cycle MEM+WB stall while SRAM data changes
    issue(mk(5'h0, 32'hBFC0_0020, 1'b1, 4'h0, 3'b000, 1'b1, 1'b1, 5'd10, 32'h0000_3000));
    data_sram_rdata = 32'hCAFE_F00D; #1;
    chk_out("lw_first", 5'h0, 32'hBFC0_0020, 1'b1, 5'd10, 32'hCAFE_F00D);
    stall = 6'b011111;
    ex_to_mem_bus = mk(5'h0, 32'hBFC0_0024, 1'b1, 4'h0, 3'b000, 1'b1, 1'b1, 5'd11, 32'h0000_4000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_sram_rdata = 32'hDEAD_BEEF; #1;
      chk_out("lw_hold", 5'h0, 32'hBFC0_0020, 1'b1, 5'd10, 32'hCAFE_F00D);
    end
    stall = 6'b0;
    @(negedge clk);
    data_sram_rdata = 32'h1122_3344; #1;
    chk_out("lw_after", 5'h0, 32'hBFC0_0024, 1'b1, 5'd11, 32'h1122_3344);

    // Bubble: MEM stalled, WB running
    stall = 6'b001111;
    @(negedge clk); #1;
    chk_out("bubble", 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    stall = 6'b0;

    // Flush a valid entry
    issue(mk(5'h2, 32'hBFC0_0028, 1'b0, 4'h0, 3'b000, 1'b0, 1'b1, 5'd12, 32'h0BAD_F00D));
    #1;
    chk_out("pre_flush", 5'h2, 32'hBFC0_0028, 1'b1, 5'd12, 32'h0BAD_F00D);
    flush = 1'b1;
    @(negedge clk); #1;
    chk_out("flush", 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    flush = 1'b0;

    // Reset in the middle of a held load
    issue(mk(5'h0, 32'hBFC0_002C, 1'b1, 4'h0, 3'b000, 1'b1, 1'b1, 5'd13, 32'h0000_0000));
    data_sram_rdata = 32'hA5A5_A5A5;
    stall = 6'b011111;
    @(negedge clk);
    data_sram_rdata = 32'h0000_0000; #1;
    chk_out("rst_held", 5'h0, 32'hBFC0_002C, 1'b1, 5'd13, 32'hA5A5_A5A5);
    rst = 1'b1;
    @(negedge clk); #1;
    chk_out("rst_mid", 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    chk("rst_held_flag", {74'h0, dut.r_rdata_held}, 75'h0);
    rst = 1'b0;
    stall = 6'b0;
    issue(mk(5'h0, 32'hBFC0_0030, 1'b1, 4'h0, 3'b000, 1'b1, 1'b1, 5'd14, 32'h0000_0008));
    data_sram_rdata = 32'h5A5A_0000; #1;
    chk_out("post_rst_lw", 5'h0, 32'hBFC0_0030, 1'b1, 5'd14, 32'h5A5A_0000);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

`default_nettype wire
